processing_unit_weighted: RTL and testbench

Per-ancilla processing element for the union-find decoder grid, successor to the single-FPGA PE. It adds:
- internal per-edge growth counters with a configurable integer weight per edge, so weighted growth needs no external edge logic;
- a one-hot parent selection;
- boundary contact that counts only fully grown boundary edges.

One instance sits at each ancilla. The controller steps it through `global_stage`, and it exchanges root, parity and growth signals with up to `NEIGHBOR_COUNT` neighbours.

---
 rtl/processing_unit_weighted_pkg.sv | 20 ++
 rtl/min_val_less_8x_with_index.sv | 44 ++++
 rtl/processing_unit_weighted_edge_growth_counter.sv | 59 +++++
 rtl/processing_unit_weighted.sv | 173 +++++++++++++++++
 tb/tb_processing_unit_weighted.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/processing_unit_weighted_pkg.sv
// ============================================================================
// Module      : processing_unit_weighted_pkg
// Description : Controller stage encoding shared by the union-find PE grid.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package processing_unit_weighted_pkg;

    localparam int STAGE_WIDTH = 3;

    localparam logic [STAGE_WIDTH-1:0] STAGE_IDLE                = 3'd0;
    localparam logic [STAGE_WIDTH-1:0] STAGE_MEASUREMENT_LOADING = 3'd1;
    localparam logic [STAGE_WIDTH-1:0] STAGE_GROW                = 3'd2;
    localparam logic [STAGE_WIDTH-1:0] STAGE_MERGE               = 3'd3;
    localparam logic [STAGE_WIDTH-1:0] STAGE_PEELING             = 3'd4;

endpackage

`default_nettype wire

// File: rtl/min_val_less_8x_with_index.sv
// ============================================================================
// Module      : min_val_less_8x_with_index
// Description : Minimum over up to 8 valid channels; ties resolve to the
//               lowest channel index.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module min_val_less_8x_with_index #(
    parameter int DATA_WIDTH    = 6,
    parameter int CHANNEL_COUNT = 8
) (
    input  logic [CHANNEL_COUNT*DATA_WIDTH-1:0] i_values,
    input  logic [CHANNEL_COUNT-1:0]            i_valids,
    output logic [DATA_WIDTH-1:0]               o_result,
    output logic [2:0]                          o_index,
    output logic                                o_any_valid
);

    logic [DATA_WIDTH-1:0] w_result;
    logic [2:0]            w_index;
    logic                  w_any;

    // Strict less-than keeps the earliest channel on equal values.
    always_comb begin
        w_result = '0;
        w_index  = '0;
        w_any    = 1'b0;
        for (int i = 0; i < CHANNEL_COUNT; i++) begin
            if (i_valids[i] && (!w_any || (i_values[i*DATA_WIDTH +: DATA_WIDTH] < w_result))) begin
                w_result = i_values[i*DATA_WIDTH +: DATA_WIDTH];
                w_index  = 3'(i);
                w_any    = 1'b1;
            end
        end
    end

    assign o_result    = w_result;
    assign o_index     = w_index;
    assign o_any_valid = w_any;

endmodule

`default_nettype wire

// File: rtl/processing_unit_weighted_edge_growth_counter.sv
// ============================================================================
// Module      : edge_growth_counter
// Description : Per-edge weight latch and saturating growth counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module edge_growth_counter #(
    parameter int WEIGHT_WIDTH = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_load,
    input  logic                    i_grow_entry,
    input  logic [WEIGHT_WIDTH-1:0] i_weight,
    input  logic [1:0]              i_inc,
    output logic                    o_fully_grown,
    output logic                    o_changed
);

    logic [WEIGHT_WIDTH-1:0] r_weight_q;
    logic [WEIGHT_WIDTH-1:0] w_weight_d;
    logic [WEIGHT_WIDTH-1:0] r_count_q;
    logic [WEIGHT_WIDTH-1:0] w_count_d;
    logic [WEIGHT_WIDTH:0]   w_sum;

    // One extra bit so count+2 cannot wrap before the saturation compare.
    always_comb begin
        w_weight_d = r_weight_q;
        w_count_d  = r_count_q;
        w_sum      = {1'b0, r_count_q} + (WEIGHT_WIDTH+1)'(i_inc);
        if (i_load) begin
            w_weight_d = i_weight;
            w_count_d  = '0;
        end else if (i_grow_entry) begin
            if (w_sum > {1'b0, r_weight_q}) begin
                w_count_d = r_weight_q;
            end else begin
                w_count_d = w_sum[WEIGHT_WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_weight_q <= '0;
            r_count_q  <= '0;
        end else begin
            r_weight_q <= w_weight_d;
            r_count_q  <= w_count_d;
        end
    end

    assign o_fully_grown = (r_weight_q != '0) && (r_count_q == r_weight_q);
    assign o_changed     = i_grow_entry && (w_count_d != r_count_q);

endmodule

`default_nettype wire

// File: rtl/processing_unit_weighted.sv
// ============================================================================
// Module      : processing_unit_weighted
// Description : Per-ancilla union-find PE with weighted edge growth.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module processing_unit_weighted
    import processing_unit_weighted_pkg::*;
#(
    parameter int                     NEIGHBOR_COUNT = 6,
    parameter int                     ADDRESS_WIDTH  = 6,
    parameter int                     WEIGHT_WIDTH   = 2,
    parameter logic [ADDRESS_WIDTH-1:0] ADDRESS      = '0
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   measurement,
    input  logic [STAGE_WIDTH-1:0]                 global_stage,
    input  logic [NEIGHBOR_COUNT*WEIGHT_WIDTH-1:0] edge_weight,
    input  logic [NEIGHBOR_COUNT-1:0]              neighbor_increase,
    input  logic [NEIGHBOR_COUNT-1:0]              neighbor_is_boundary,
    input  logic [NEIGHBOR_COUNT*ADDRESS_WIDTH-1:0] neighbor_root,
    input  logic [NEIGHBOR_COUNT-1:0]              neighbor_parent_vector,
    input  logic [NEIGHBOR_COUNT-1:0]              parent_odd,
    input  logic [NEIGHBOR_COUNT-1:0]              child_cluster_parity,
    input  logic [NEIGHBOR_COUNT-1:0]              child_touching_boundary,
    output logic                                   increase,
    output logic [NEIGHBOR_COUNT-1:0]              fully_grown,
    output logic [NEIGHBOR_COUNT-1:0]              parent_vector,
    output logic                                   cluster_parity,
    output logic                                   cluster_touching_boundary,
    output logic                                   odd,
    output logic [ADDRESS_WIDTH-1:0]               root,
    output logic                                   busy
);

    logic [STAGE_WIDTH-1:0]    r_stage_q;
    logic [STAGE_WIDTH-1:0]    r_last_stage_q;
    logic                      r_m_q,      w_m_d;
    logic [ADDRESS_WIDTH-1:0]  r_root_q,   w_root_d;
    logic [NEIGHBOR_COUNT-1:0] r_pv_q,     w_pv_d;
    logic                      r_parity_q, w_parity_d;
    logic                      r_ctb_q,    w_ctb_d;
    logic                      r_odd_q,    w_odd_d;
    logic                      r_busy_q,   w_busy_d;

    logic                      w_load;
    logic                      w_merge;
    logic                      w_grow_entry;
    logic [NEIGHBOR_COUNT-1:0] w_edge_changed;
    logic [NEIGHBOR_COUNT-1:0] w_root_valid;
    logic [ADDRESS_WIDTH-1:0]  w_min_root;
    logic [2:0]                w_min_index;
    logic                      w_min_any;
    logic [NEIGHBOR_COUNT-1:0] w_min_onehot;
    logic                      w_next_p;
    logic                      w_next_b;

    assign w_load       = (r_stage_q == STAGE_MEASUREMENT_LOADING);
    assign w_merge      = (r_stage_q == STAGE_MERGE);
    assign w_grow_entry = (r_stage_q == STAGE_GROW) && (r_last_stage_q != STAGE_GROW);

    assign increase = r_odd_q && w_grow_entry;

    // Boundary channels have no PE on the far end, so only our own pulse grows them.
    generate
        for (genvar gi = 0; gi < NEIGHBOR_COUNT; gi++) begin : g_edge
            logic [1:0] w_inc;
            assign w_inc = {1'b0, increase}
                         + (neighbor_is_boundary[gi] ? 2'd0 : {1'b0, neighbor_increase[gi]});

            edge_growth_counter #(
                .WEIGHT_WIDTH (WEIGHT_WIDTH)
            ) u_counter (
                .clk           (clk),
                .reset         (reset),
                .i_load        (w_load),
                .i_grow_entry  (w_grow_entry),
                .i_weight      (edge_weight[gi*WEIGHT_WIDTH +: WEIGHT_WIDTH]),
                .i_inc         (w_inc),
                .o_fully_grown (fully_grown[gi]),
                .o_changed     (w_edge_changed[gi])
            );
        end
    endgenerate

    assign w_root_valid = fully_grown & ~neighbor_is_boundary;

    min_val_less_8x_with_index #(
        .DATA_WIDTH    (ADDRESS_WIDTH),
        .CHANNEL_COUNT (NEIGHBOR_COUNT)
    ) u_min_root (
        .i_values    (neighbor_root),
        .i_valids    (w_root_valid),
        .o_result    (w_min_root),
        .o_index     (w_min_index),
        .o_any_valid (w_min_any)
    );

    assign w_min_onehot = NEIGHBOR_COUNT'(1) << w_min_index;

    assign w_next_p = (^(neighbor_parent_vector & child_cluster_parity)) ^ r_m_q;
    assign w_next_b = (|(neighbor_parent_vector & child_touching_boundary))
                    | (|(fully_grown & neighbor_is_boundary));

    always_comb begin
        w_m_d      = r_m_q;
        w_root_d   = r_root_q;
        w_pv_d     = r_pv_q;
        w_parity_d = r_parity_q;
        w_ctb_d    = r_ctb_q;
        w_odd_d    = r_odd_q;
        w_busy_d   = r_busy_q;
        if (w_load) begin
            w_m_d      = measurement;
            w_parity_d = measurement;
            w_odd_d    = measurement;
            w_root_d   = ADDRESS;
            w_pv_d     = '0;
            w_ctb_d    = 1'b0;
            w_busy_d   = 1'b0;
        end else if (w_merge) begin
            if (w_min_any && (w_min_root < r_root_q)) begin
                w_root_d = w_min_root;
                w_pv_d   = w_min_onehot;
            end
            w_parity_d = w_next_p;
            w_ctb_d    = w_next_b;
            // A rooted child follows its parent's oddness; a root decides for itself.
            w_odd_d    = (|r_pv_q) ? (|(r_pv_q & parent_odd)) : (w_next_p & ~w_next_b);
            w_busy_d   = (w_root_d != r_root_q) || (w_pv_d != r_pv_q)
                      || (w_parity_d != r_parity_q) || (w_ctb_d != r_ctb_q)
                      || (w_odd_d != r_odd_q);
        end else if (w_grow_entry) begin
            w_busy_d = |w_edge_changed;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stage_q      <= STAGE_IDLE;
            r_last_stage_q <= STAGE_IDLE;
            r_m_q          <= 1'b0;
            r_root_q       <= ADDRESS;
            r_pv_q         <= '0;
            r_parity_q     <= 1'b0;
            r_ctb_q        <= 1'b0;
            r_odd_q        <= 1'b0;
            r_busy_q       <= 1'b0;
        end else begin
            r_stage_q      <= global_stage;
            r_last_stage_q <= r_stage_q;
            r_m_q          <= w_m_d;
            r_root_q       <= w_root_d;
            r_pv_q         <= w_pv_d;
            r_parity_q     <= w_parity_d;
            r_ctb_q        <= w_ctb_d;
            r_odd_q        <= w_odd_d;
            r_busy_q       <= w_busy_d;
        end
    end

    assign parent_vector             = r_pv_q;
    assign cluster_parity            = r_parity_q;
    assign cluster_touching_boundary = r_ctb_q;
    assign odd                       = r_odd_q;
    assign root                      = r_root_q;
    assign busy                      = r_busy_q;

endmodule

`default_nettype wire

// File: tb/tb_processing_unit_weighted.sv
// ============================================================================
// Module      : tb_processing_unit_weighted
// Description : Scoreboard bench for processing_unit_weighted (ADDRESS = 5).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_processing_unit_weighted;
    import processing_unit_weighted_pkg::*;

    localparam int N  = 6;
    localparam int AW = 6;
    localparam int WW = 2;

    logic               clk = 1'b0;
    logic               reset;
    logic               measurement;
    logic [STAGE_WIDTH-1:0] global_stage;
    logic [N*WW-1:0]    edge_weight;
    logic [N-1:0]       neighbor_increase;
    logic [N-1:0]       neighbor_is_boundary;
    logic [N*AW-1:0]    neighbor_root;
    logic [N-1:0]       neighbor_parent_vector;
    logic [N-1:0]       parent_odd;
    logic [N-1:0]       child_cluster_parity;
    logic [N-1:0]       child_touching_boundary;
    logic               increase;
    logic [N-1:0]       fully_grown;
    logic [N-1:0]       parent_vector;
    logic               cluster_parity;
    logic               cluster_touching_boundary;
    logic               odd;
    logic [AW-1:0]      root;
    logic               busy;

    processing_unit_weighted #(
        .NEIGHBOR_COUNT (N),
        .ADDRESS_WIDTH  (AW),
        .WEIGHT_WIDTH   (WW),
        .ADDRESS        (6'd5)
    ) dut (
        .clk                       (clk),
        .reset                     (reset),
        .measurement               (measurement),
        .global_stage              (global_stage),
        .edge_weight               (edge_weight),
        .neighbor_increase         (neighbor_increase),
        .neighbor_is_boundary      (neighbor_is_boundary),
        .neighbor_root             (neighbor_root),
        .neighbor_parent_vector    (neighbor_parent_vector),
        .parent_odd                (parent_odd),
        .child_cluster_parity      (child_cluster_parity),
        .child_touching_boundary   (child_touching_boundary),
        .increase                  (increase),
        .fully_grown               (fully_grown),
        .parent_vector             (parent_vector),
        .cluster_parity            (cluster_parity),
        .cluster_touching_boundary (cluster_touching_boundary),
        .odd                       (odd),
        .root                      (root),
        .busy                      (busy)
    );

    always #5 clk = ~clk;

    typedef enum int {K_INC, K_FG, K_PV, K_PAR, K_CTB, K_ODD, K_ROOT, K_BUSY} kind_t;
    typedef struct {
        int          cyc;
        kind_t       kind;
        int unsigned val;
        string       name;
    } exp_t;

    exp_t sb_q[$];
    int   cyc    = 0;
    int   n_vec  = 0;
    int   n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int unsigned actual_of(kind_t k);
        case (k)
            K_INC:   return 32'(increase);
            K_FG:    return 32'(fully_grown);
            K_PV:    return 32'(parent_vector);
            K_PAR:   return 32'(cluster_parity);
            K_CTB:   return 32'(cluster_touching_boundary);
            K_ODD:   return 32'(odd);
            K_ROOT:  return 32'(root);
            default: return 32'(busy);
        endcase
    endfunction

    // Monitor: pops every expectation due in the current cycle, mid-cycle.
    always @(negedge clk) begin : monitor
        exp_t        e;
        int unsigned act;
        while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
            e   = sb_q.pop_front();
            act = actual_of(e.kind);
            n_vec++;
            if (e.cyc != cyc) begin
                n_fail++;
                $display("FAIL %s: sampled in cycle %0d, required cycle %0d", e.name, cyc, e.cyc);
            end else if (act != e.val) begin
                n_fail++;
                $display("FAIL %s: got 'h%0h, expected 'h%0h (cycle %0d)", e.name, act, e.val, cyc);
            end
        end
    end

    task automatic chk(input kind_t k, input int unsigned v, input string nm);
        exp_t e;
        e.cyc  = cyc;
        e.kind = k;
        e.val  = v;
        e.name = nm;
        sb_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic m);
        measurement  = m;
        global_stage = STAGE_MEASUREMENT_LOADING;
        step();
        step();
        global_stage = STAGE_IDLE;
        step();
        step();
    endtask

    // GROW held for n cycles, then IDLE; returns with counters settled.
    task automatic do_grow(input int n, input logic exp_inc, input string nm);
        global_stage = STAGE_GROW;
        step();
        chk(K_INC, 32'(exp_inc), {nm, "_increase"});
        for (int k = 1; k < n; k++) begin
            step();
            chk(K_INC, 0, {nm, "_increase_repeat"});
        end
        global_stage = STAGE_IDLE;
        step();
        step();
    endtask

    // Returns in the cycle showing the first merge cycle's results.
    task automatic merge_begin();
        global_stage = STAGE_MERGE;
        step();
        step();
    endtask

    task automatic merge_end();
        global_stage = STAGE_IDLE;
        step();
        step();
    endtask

    initial begin
        reset                   = 1'b0;
        measurement             = 1'b0;
        global_stage            = STAGE_IDLE;
        edge_weight             = '0;
        neighbor_increase       = '0;
        neighbor_is_boundary    = '0;
        neighbor_root           = {6'd9, 6'd9, 6'd9, 6'd9, 6'd9, 6'd9};
        neighbor_parent_vector  = '0;
        parent_odd              = '0;
        child_cluster_parity    = '0;
        child_touching_boundary = '0;
        step();
        step();
        chk(K_ROOT, 5, "rst_root");
        chk(K_PV,   0, "rst_parent_vector");
        chk(K_ODD,  0, "rst_odd");
        chk(K_BUSY, 0, "rst_busy");
        chk(K_INC,  0, "rst_increase");
        chk(K_FG,   0, "rst_fully_grown");
        step();
        reset = 1'b1;
        step();

        // Load and weight-3 growth with a silent neighbour
        edge_weight = 12'h003;
        do_load(1'b1);
        chk(K_ODD,  1, "load_odd");
        chk(K_PAR,  1, "load_parity");
        chk(K_ROOT, 5, "load_root");
        chk(K_PV,   0, "load_parent_vector");
        chk(K_BUSY, 0, "load_busy");
        do_grow(1, 1'b1, "w3_e1");
        chk(K_FG, 0, "w3_e1_fg");
        chk(K_BUSY, 1, "w3_e1_busy");
        do_grow(1, 1'b1, "w3_e2");
        chk(K_FG, 0, "w3_e2_fg");
        do_grow(1, 1'b1, "w3_e3");
        chk(K_FG, 6'b000001, "w3_e3_fg");
        chk(K_BUSY, 1, "w3_e3_busy");
        do_grow(3, 1'b1, "w3_b2b");
        chk(K_FG, 6'b000001, "w3_sat_fg");
        chk(K_BUSY, 0, "w3_sat_busy");

        // Simultaneous growth on ch0; ch5 absent edge with constant pulses
        neighbor_increase = 6'b100001;
        do_load(1'b1);
        chk(K_FG, 0, "sim_load_fg");
        do_grow(1, 1'b1, "sim_e1");
        chk(K_FG, 0, "sim_e1_fg");
        chk(K_BUSY, 1, "sim_e1_busy");
        do_grow(1, 1'b1, "sim_e2");
        chk(K_FG, 6'b000001, "sim_e2_fg");
        do_grow(1, 1'b1, "sim_e3");
        chk(K_FG, 6'b000001, "absent_fg");
        chk(K_BUSY, 0, "absent_busy");

        // Root tie on ch1/ch2, then async reset mid-merge
        edge_weight       = 12'h014;
        neighbor_increase = 6'b000110;
        neighbor_root     = {6'd9, 6'd9, 6'd7, 6'd2, 6'd2, 6'd1};
        do_load(1'b0);
        chk(K_ODD, 0, "tie_load_odd");
        do_grow(1, 1'b0, "tie_grow");
        chk(K_FG, 6'b000110, "tie_fg");
        chk(K_BUSY, 1, "tie_grow_busy");
        merge_begin();
        chk(K_ROOT, 2, "tie_root");
        chk(K_PV, 6'b000010, "tie_parent_vector");
        chk(K_BUSY, 1, "tie_busy_first");
        chk(K_ODD, 0, "tie_odd");
        step();
        chk(K_BUSY, 0, "tie_busy_second");
        chk(K_ROOT, 2, "tie_root_hold");
        step();
        reset = 1'b0;
        chk(K_ROOT, 5, "arst_root");
        chk(K_PV, 0, "arst_parent_vector");
        chk(K_FG, 0, "arst_fully_grown");
        chk(K_BUSY, 0, "arst_busy");
        step();
        global_stage = STAGE_IDLE;
        reset        = 1'b1;
        step();
        step();

        // Boundary edge on ch3 with a lower root that must never be adopted
        edge_weight          = 12'h040;
        neighbor_increase    = 6'b001000;
        neighbor_is_boundary = 6'b001000;
        neighbor_root        = {6'd9, 6'd9, 6'd0, 6'd9, 6'd9, 6'd9};
        do_load(1'b1);
        merge_begin();
        chk(K_CTB, 0, "bnd_pre_ctb");
        chk(K_ODD, 1, "bnd_pre_odd");
        chk(K_BUSY, 0, "bnd_pre_busy");
        merge_end();
        do_grow(1, 1'b1, "bnd_grow");
        chk(K_FG, 6'b001000, "bnd_fg");
        merge_begin();
        chk(K_CTB, 1, "bnd_ctb");
        chk(K_ODD, 0, "bnd_odd");
        chk(K_ROOT, 5, "bnd_root");
        chk(K_PV, 0, "bnd_parent_vector");
        chk(K_PAR, 1, "bnd_parity");
        chk(K_BUSY, 1, "bnd_busy");
        merge_end();

        for (int i = 0; i < 20 && sb_q.size() > 0; i++) step();
        if (sb_q.size() > 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL drain: %0d expectations never sampled, required 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
